// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: drives a req/ack data-memory port for loads and stores,
// stalls upstream while an access is outstanding and flags bad accesses/timeouts.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic              i_RegWrite,
  input  logic              i_MemToReg,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_stall,
  output logic              o_RegWrite,
  output logic              o_MemToReg,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [DATA_W-1:0] o_alu_data,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_exc,
  output logic              o_bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata
);

  // state  | meaning
  // S_IDLE | pass-through; launches a good memory op
  // S_WAIT | request outstanding, waiting for ack or timeout
  // S_DONE | one cycle presenting the latched result to MEM/WB
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              berr_q, berr_d;

  logic mem_op, bad;

  assign mem_op = i_valid & (i_MemRead | i_MemWrite);
  assign bad    = mem_op & ((i_MemRead & i_MemWrite) | (i_alu_data[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_q      <= '0;
      rd_q       <= '0;
      mdata_q    <= '0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      mdata_q    <= mdata_d;
      berr_q     <= berr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    mdata_d    = mdata_q;
    berr_d     = berr_q;
    o_stall    = 1'b0;
    o_RegWrite = 1'b0;
    o_MemToReg = 1'b0;
    o_mem_data = '0;
    o_alu_data = '0;
    o_rd       = '0;
    o_exc      = 1'b0;
    o_bus_err  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op && !bad) begin
          o_stall    = 1'b1;
          state_d    = S_WAIT;
          cnt_d      = '0;
          req_d      = 1'b1;
          we_d       = i_MemWrite;
          addr_d     = i_alu_data;
          wdata_d    = i_wdata;
          regwrite_d = i_RegWrite;
          memtoreg_d = i_MemToReg;
          alu_d      = i_alu_data;
          rd_d       = i_rd;
          mdata_d    = '0;
          berr_d     = 1'b0;
        end else begin
          o_RegWrite = i_valid & i_RegWrite & ~bad;
          o_MemToReg = i_MemToReg;
          o_alu_data = i_alu_data;
          o_rd       = i_rd;
          o_exc      = bad;
        end
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (dmem_ack) begin
          mdata_d = we_q ? '0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d      = 1'b0;
          regwrite_d = 1'b0;
          mdata_d    = '0;
          berr_d     = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        o_RegWrite = regwrite_q;
        o_MemToReg = memtoreg_q;
        o_mem_data = mdata_q;
        o_alu_data = alu_q;
        o_rd       = rd_q;
        o_bus_err  = berr_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs stay quiet while reset is held, whatever the inputs show.
    if (rst) begin
      o_stall   = 1'b0;
      o_exc     = 1'b0;
      o_bus_err = 1'b0;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
